enable_delay_pipe: RTL and testbench

ENABLE_DELAY_PIPE -- requirements
Module: enable_delay_pipe

---
 rtl/enable_delay_pipe.sv | 151 +++++++++++++++
 tb/tb_enable_delay_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enable_delay_pipe.sv
// enable_delay_pipe
//   Delays a level enable by exactly DELAY clock cycles through a shift
//   register, flags when the pipeline has been filled since reset (primed),
//   and emits one-cycle rise/fall pulses on transitions of the delayed enable.
//
//   Optional feature macro: ENABLE_DELAY_PIPE_STAT_EN
//     defined   -> toggle_cnt port plus a saturating transition counter,
//                  cleared synchronously by cnt_clr.
//     undefined -> no toggle_cnt port; cnt_clr is accepted and ignored.
//
//   Reset is asynchronous, active-low. Release must already be synchronous
//   to clk; there is no internal reset synchronizer.
module enable_delay_pipe #(
    parameter int unsigned DELAY = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic             cnt_clr,
    output logic             enable_out,
    output logic             primed,
    output logic             rise_pulse,
    output logic             fall_pulse
`ifdef ENABLE_DELAY_PIPE_STAT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    // Fill counter only has to reach DELAY-1.
    localparam int unsigned FW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(DELAY - 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reject out-of-range configurations at elaboration.
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
        $error("enable_delay_pipe: DELAY must be in 1..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("enable_delay_pipe: CNT_W must be at least 1");
    end

    logic [DELAY-1:0] r_stage;
    logic [DELAY-1:0] w_stage_nxt;
    state_t           r_state;
    logic [FW-1:0]    r_fill_cnt;
    logic             r_primed;
    logic             r_enable_out_d;
    logic             r_rise;
    logic             r_fall;
    logic             w_enter_run;
    logic             w_primed_nxt;
    logic             w_out_nxt;

    // Next shift-register contents: stage 0 takes enable_in, others shift up.
    always_comb begin
        w_stage_nxt    = '0;
        w_stage_nxt[0] = enable_in;
        for (int unsigned i = 1; i < DELAY; i++) begin
            w_stage_nxt[i] = r_stage[i-1];
        end
    end

    // Look-ahead of primed and enable_out so pulses line up with them.
    always_comb begin
        w_enter_run  = (r_state == FILL) && (r_fill_cnt == FILL_LAST);
        w_primed_nxt = r_primed | w_enter_run;
        w_out_nxt    = w_stage_nxt[DELAY-1];
    end

    // Delay line; reset fills every stage with 0 so the output is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_stage_nxt;
        end
    end

    // Fill FSM: count DELAY edges after reset, then stay in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
            r_primed   <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (r_fill_cnt == FILL_LAST) begin
                        r_state  <= RUN;
                        r_primed <= 1'b1;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + FW'(1);
                    end
                end
                RUN: begin
                    r_primed <= 1'b1;
                end
                default: begin
                    r_state  <= FILL;
                    r_primed <= 1'b0;
                end
            endcase
        end
    end

    // Edge pulses are computed from next-state values so that, as seen at the
    // outputs, rise = out & ~out_d & primed and fall = out_d & ~out & primed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable_out_d <= 1'b0;
            r_rise         <= 1'b0;
            r_fall         <= 1'b0;
        end else begin
            r_enable_out_d <= r_stage[DELAY-1];
            r_rise         <= w_primed_nxt &  w_out_nxt & ~r_stage[DELAY-1];
            r_fall         <= w_primed_nxt & ~w_out_nxt &  r_stage[DELAY-1];
        end
    end

    assign enable_out = r_stage[DELAY-1];
    assign primed     = r_primed;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

`ifdef ENABLE_DELAY_PIPE_STAT_EN
    logic [CNT_W-1:0] r_toggle_cnt;

    // Saturating transition counter; counts the cycle after a pulse, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle_cnt <= '0;
        end else if (cnt_clr) begin
            r_toggle_cnt <= '0;
        end else if ((r_rise | r_fall) && (r_toggle_cnt != '1)) begin
            r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_enable_delay_pipe.sv
// Testbench for enable_delay_pipe (DELAY=2, CNT_W=16).
// A reference queue holds every sampled enable_in; once DELAY samples are
// queued the oldest is popped as the expected enable_out. Counter checks are
// compiled in only when ENABLE_DELAY_PIPE_STAT_EN is defined.
`timescale 1ns/1ps
module tb_enable_delay_pipe;

    localparam int unsigned DELAY = 2;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable_in = 1'b0;
    logic cnt_clr = 1'b0;
    logic enable_out, primed, rise_pulse, fall_pulse;
`ifdef ENABLE_DELAY_PIPE_STAT_EN
    logic [CNT_W-1:0] toggle_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit               exp_q[$];
    logic             exp_out = 1'b0;
    logic             exp_out_d = 1'b0;
    logic             exp_primed = 1'b0;
    logic             exp_rise = 1'b0;
    logic             exp_fall = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               edges = 0;

    enable_delay_pipe #(
        .DELAY (DELAY),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_in  (enable_in),
        .cnt_clr    (cnt_clr),
        .enable_out (enable_out),
        .primed     (primed),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef ENABLE_DELAY_PIPE_STAT_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        exp_q.delete();
        exp_out    = 1'b0;
        exp_out_d  = 1'b0;
        exp_primed = 1'b0;
        exp_rise   = 1'b0;
        exp_fall   = 1'b0;
        exp_cnt    = '0;
        edges      = 0;
    endtask

    // Drive inputs, take one edge, advance the reference model.
    task automatic drive_edge(input logic ein, input logic clr);
        enable_in = ein;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
        edges++;
        exp_q.push_back(ein);
        if (clr) exp_cnt = '0;
        else if ((exp_rise | exp_fall) && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        exp_primed = (edges >= int'(DELAY));
        exp_out_d  = exp_out;
        if (exp_q.size() == DELAY) exp_out = exp_q.pop_front();
        else exp_out = 1'b0;
        exp_rise = exp_primed &  exp_out & ~exp_out_d;
        exp_fall = exp_primed & ~exp_out &  exp_out_d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if ({enable_out, primed, rise_pulse, fall_pulse} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset.outputs: got %b expected 0000",
                     {enable_out, primed, rise_pulse, fall_pulse});
        end
`ifdef ENABLE_DELAY_PIPE_STAT_EN
        n_checks++;
        if (toggle_cnt !== '0) begin
            n_errors++;
            $display("FAIL reset.toggle_cnt: got %h expected 0000", toggle_cnt);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_fill_high();
        int rises = 0;
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b1, 1'b0);
            if (rise_pulse === 1'b1) rises++;
            n_checks++;
            if ({enable_out, primed, rise_pulse, fall_pulse} !==
                {exp_out, exp_primed, exp_rise, exp_fall}) begin
                n_errors++;
                $display("FAIL fill.cycle%0d out/primed/rise/fall: got %b expected %b", i,
                         {enable_out, primed, rise_pulse, fall_pulse},
                         {exp_out, exp_primed, exp_rise, exp_fall});
            end
            if (i == 0) begin
                n_checks++;
                if (primed !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fill.primed_edge1: got %b expected 0", primed);
                end
            end
            if (i == 1) begin
                n_checks++;
                if ({primed, enable_out} !== 2'b11) begin
                    n_errors++;
                    $display("FAIL fill.primed_edge2: got %b expected 11", {primed, enable_out});
                end
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_errors++;
            $display("FAIL fill.rise_count: got %0d expected 1", rises);
        end
`ifdef ENABLE_DELAY_PIPE_STAT_EN
        n_checks++;
        if (toggle_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL fill.toggle_cnt: got %h expected 0001", toggle_cnt);
        end
`endif
    endtask

    task automatic test_pattern();
        bit pat[8] = '{0, 0, 1, 0, 1, 1, 0, 0};
        bit seq[$];
        logic [CNT_W-1:0] cnt0 = '0;
        for (int i = 0; i < 4; i++) drive_edge(1'b0, 1'b0);
`ifdef ENABLE_DELAY_PIPE_STAT_EN
        cnt0 = toggle_cnt;
`endif
        for (int i = 2; i < 8; i++) seq.push_back(pat[i]);
        for (int i = 0; i < 5; i++) seq.push_back(1'b0);
        for (int i = 0; i < seq.size(); i++) begin
            drive_edge(seq[i], 1'b0);
            n_checks++;
            if ({enable_out, primed, rise_pulse, fall_pulse} !==
                {exp_out, exp_primed, exp_rise, exp_fall}) begin
                n_errors++;
                $display("FAIL pattern.cycle%0d out/primed/rise/fall: got %b expected %b", i,
                         {enable_out, primed, rise_pulse, fall_pulse},
                         {exp_out, exp_primed, exp_rise, exp_fall});
            end
        end
`ifdef ENABLE_DELAY_PIPE_STAT_EN
        n_checks++;
        if (toggle_cnt - cnt0 !== 16'd4) begin
            n_errors++;
            $display("FAIL pattern.toggle_delta: got %0d expected 4", toggle_cnt - cnt0);
        end
`endif
    endtask

    task automatic test_single_pulse();
        int rise_at = -1;
        int fall_at = -1;
        int high_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            drive_edge((i == 1) ? 1'b1 : 1'b0, 1'b0);
            if (enable_out === 1'b1) high_cycles++;
            if (rise_pulse === 1'b1) rise_at = i;
            if (fall_pulse === 1'b1) fall_at = i;
            n_checks++;
            if ({enable_out, rise_pulse, fall_pulse} !== {exp_out, exp_rise, exp_fall}) begin
                n_errors++;
                $display("FAIL single.cycle%0d out/rise/fall: got %b expected %b", i,
                         {enable_out, rise_pulse, fall_pulse}, {exp_out, exp_rise, exp_fall});
            end
        end
        n_checks++;
        if (high_cycles != 1 || rise_at != 2 || fall_at != 3) begin
            n_errors++;
            $display("FAIL single.shape: got high=%0d rise@%0d fall@%0d expected high=1 rise@2 fall@3",
                     high_cycles, rise_at, fall_at);
        end
    endtask

`ifdef ENABLE_DELAY_PIPE_STAT_EN
    task automatic test_saturation();
        logic h = 1'b0;
        int budget = 0;
        drive_edge(1'b0, 1'b1);
        n_checks++;
        if (toggle_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL sat.clear_start: got %h expected 0000", toggle_cnt);
        end
        while (exp_cnt != 16'hFFFE && budget < 70000) begin
            h = ~h;
            drive_edge(h, 1'b0);
            budget++;
        end
        n_checks++;
        if (toggle_cnt !== exp_cnt || budget >= 70000) begin
            n_errors++;
            $display("FAIL sat.reach_fffe: got %h expected %h (cycles %0d)", toggle_cnt, exp_cnt, budget);
        end
        for (int i = 0; i < 3; i++) begin
            h = ~h;
            drive_edge(h, 1'b0);
        end
        for (int i = 0; i < 5; i++) drive_edge(h, 1'b0);
        n_checks++;
        if (toggle_cnt !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL sat.hold_ffff: got %h expected ffff", toggle_cnt);
        end
        h = ~h;
        drive_edge(h, 1'b0);
        drive_edge(h, 1'b0);
        n_checks++;
        if ((rise_pulse | fall_pulse) !== 1'b1) begin
            n_errors++;
            $display("FAIL sat.pulse_before_clr: got %b expected 1", rise_pulse | fall_pulse);
        end
        drive_edge(h, 1'b1);
        n_checks++;
        if (toggle_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL sat.clr_wins: got %h expected 0000", toggle_cnt);
        end
        drive_edge(h, 1'b0);
        n_checks++;
        if (toggle_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL sat.after_clr: got %h expected 0000", toggle_cnt);
        end
    endtask
`endif

    task automatic test_mid_reset();
        int falls = 0;
        for (int i = 0; i < 3; i++) drive_edge(1'b1, 1'b0);
        n_checks++;
        if (enable_out !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst.pre_out: got %b expected 1", enable_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({enable_out, primed, rise_pulse, fall_pulse} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midrst.async_outputs: got %b expected 0000",
                     {enable_out, primed, rise_pulse, fall_pulse});
        end
`ifdef ENABLE_DELAY_PIPE_STAT_EN
        n_checks++;
        if (toggle_cnt !== '0) begin
            n_errors++;
            $display("FAIL midrst.async_cnt: got %h expected 0000", toggle_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b1, 1'b0);
            if (fall_pulse === 1'b1) falls++;
            n_checks++;
            if ({enable_out, primed, rise_pulse, fall_pulse} !==
                {exp_out, exp_primed, exp_rise, exp_fall}) begin
                n_errors++;
                $display("FAIL midrst.cycle%0d out/primed/rise/fall: got %b expected %b", i,
                         {enable_out, primed, rise_pulse, fall_pulse},
                         {exp_out, exp_primed, exp_rise, exp_fall});
            end
        end
        n_checks++;
        if (falls != 0) begin
            n_errors++;
            $display("FAIL midrst.spurious_fall: got %0d expected 0", falls);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive_edge(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            n_checks++;
            if ({enable_out, primed, rise_pulse, fall_pulse} !==
                {exp_out, exp_primed, exp_rise, exp_fall}) begin
                n_errors++;
                $display("FAIL b2b.cycle%0d out/primed/rise/fall: got %b expected %b", i,
                         {enable_out, primed, rise_pulse, fall_pulse},
                         {exp_out, exp_primed, exp_rise, exp_fall});
            end
`ifdef ENABLE_DELAY_PIPE_STAT_EN
            n_checks++;
            if (toggle_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL b2b.cycle%0d toggle_cnt: got %h expected %h", i, toggle_cnt, exp_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill_high();
        test_pattern();
        test_single_pulse();
`ifdef ENABLE_DELAY_PIPE_STAT_EN
        test_saturation();
`endif
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
